// File: rtl/apu_pkg.sv
// Shared constants for the APU frame-sequencer counters.
// MODE selectors and the standard counter widths used by the channels.
package apu_pkg;

    localparam int MODE_LINEAR  = 0;
    localparam int MODE_LENGTH  = 1;

    // Triangle linear counter width.
    localparam int APU_LINEAR_W = 7;
    // Output width of the length-table lookup done in the register decoder.
    localparam int APU_LENGTH_W = 8;

endpackage

// File: rtl/apu_frame_counter_unit.sv
// One channel's frame-sequencer-driven down-counter: either the triangle
// linear counter (MODE_LINEAR) or a length counter (MODE_LENGTH).
// Ports:
//   iClk, iReset     clock, async active-high reset
//   iTick            quarter-frame (LINEAR) / half-frame (LENGTH) strobe
//   iWrite           CPU write to this channel's duration register
//   iControl_flag    LINEAR: keep reload flag set; LENGTH: halt
//   iChannel_enable  LENGTH: status enable bit (ignored in LINEAR)
//   iDuration        reload / load value
//   oData            counter nonzero, gates the channel output
//   oCount           current counter value
//   oExpired         one-cycle pulse when a decrement reaches zero
module apu_frame_counter_unit
    import apu_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int MODE  = MODE_LINEAR
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iTick,
    input  logic             iWrite,
    input  logic             iControl_flag,
    input  logic             iChannel_enable,
    input  logic [WIDTH-1:0] iDuration,
    output logic             oData,
    output logic [WIDTH-1:0] oCount,
    output logic             oExpired
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign oData    = (count_q != '0);
    assign oCount   = count_q;
    assign oExpired = expired_q;

    if (MODE == MODE_LINEAR) begin : g_linear
        logic reload_q, reload_d;
        logic unused_enable;

        assign unused_enable = iChannel_enable;

        always_ff @(posedge iClk or posedge iReset) begin
            if (iReset) begin
                reload_q <= 1'b1;
            end else begin
                reload_q <= reload_d;
            end
        end

        always_comb begin
            count_d   = count_q;
            reload_d  = reload_q;
            expired_d = 1'b0;
            if (iTick) begin
                // A write landing on the same tick already counts as a
                // pending reload.
                if (reload_q || iWrite) begin
                    count_d = iDuration;
                end else if (count_q != '0) begin
                    count_d   = count_q - WIDTH'(1);
                    expired_d = (count_q == WIDTH'(1));
                end
                if (!iControl_flag) begin
                    reload_d = 1'b0;
                end
            end
            // Write is applied last so it wins over the tick's clear.
            if (iWrite) begin
                reload_d = 1'b1;
            end
        end
    end else begin : g_length
        always_comb begin
            count_d   = count_q;
            expired_d = 1'b0;
            if (!iChannel_enable) begin
                count_d = '0;
            end else if (iWrite) begin
                count_d = iDuration;
            end else if (iTick && !iControl_flag && count_q != '0) begin
                count_d   = count_q - WIDTH'(1);
                expired_d = (count_q == WIDTH'(1));
            end
        end
    end

endmodule

// File: tb/tb_apu_frame_counter_unit.sv
// Scoreboard bench for apu_frame_counter_unit in both modes.
// Stimulus queues expected post-edge state; a monitor compares each cycle.
module tb_apu_frame_counter_unit;
    import apu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       l_tick = 0, l_write = 0, l_ctrl = 0, l_en = 0;
    logic [6:0] l_dur = '0;
    logic       l_data, l_exp;
    logic [6:0] l_count;

    logic       n_tick = 0, n_write = 0, n_ctrl = 0, n_en = 1;
    logic [7:0] n_dur = '0;
    logic       n_data, n_exp;
    logic [7:0] n_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit    sel;
        int    cnt;
        bit    ex;
        string tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    apu_frame_counter_unit #(.WIDTH(APU_LINEAR_W), .MODE(MODE_LINEAR)) u_lin (
        .iClk(clk), .iReset(rst), .iTick(l_tick), .iWrite(l_write),
        .iControl_flag(l_ctrl), .iChannel_enable(l_en), .iDuration(l_dur),
        .oData(l_data), .oCount(l_count), .oExpired(l_exp)
    );

    apu_frame_counter_unit #(.WIDTH(APU_LENGTH_W), .MODE(MODE_LENGTH)) u_len (
        .iClk(clk), .iReset(rst), .iTick(n_tick), .iWrite(n_write),
        .iControl_flag(n_ctrl), .iChannel_enable(n_en), .iDuration(n_dur),
        .oData(n_data), .oCount(n_count), .oExpired(n_exp)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input bit sel, input string tag,
                             input int cnt, input bit ex);
        if (sel == 1'b0) begin
            chk({tag, " L.count"}, int'(l_count), cnt);
            chk({tag, " L.data"}, int'(l_data), int'(cnt != 0));
            chk({tag, " L.expired"}, int'(l_exp), int'(ex));
        end else begin
            chk({tag, " N.count"}, int'(n_count), cnt);
            chk({tag, " N.data"}, int'(n_data), int'(cnt != 0));
            chk({tag, " N.expired"}, int'(n_exp), int'(ex));
        end
    endtask

    // Monitor: one queued expectation per clock edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk_state(e.sel, e.tag, e.cnt, e.ex);
        end
    end

    int step_no = 0;

    task automatic step(input bit sel, input bit tick, input bit wr,
                        input bit ctrl, input bit en, input int dur,
                        input int cnt, input bit ex);
        exp_t e;
        @(negedge clk);
        l_tick  = 1'b0;
        l_write = 1'b0;
        n_tick  = 1'b0;
        n_write = 1'b0;
        if (sel == 1'b0) begin
            l_tick  = tick;
            l_write = wr;
            l_ctrl  = ctrl;
            l_dur   = 7'(dur);
        end else begin
            n_tick  = tick;
            n_write = wr;
            n_ctrl  = ctrl;
            n_en    = en;
            n_dur   = 8'(dur);
        end
        step_no++;
        e.sel = sel;
        e.cnt = cnt;
        e.ex  = ex;
        e.tag = $sformatf("step%0d", step_no);
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        l_tick  = 1'b0;
        l_write = 1'b0;
        n_tick  = 1'b0;
        n_write = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        // Mid-cycle, well before the next edge.
        #3;
        rst = 1'b1;
        #1;
        chk_state(1'b0, {tag, " rst"}, 0, 1'b0);
        chk_state(1'b1, {tag, " rst"}, 0, 1'b0);
        @(negedge clk);
        l_tick  = 1'b0;
        l_write = 1'b0;
        n_tick  = 1'b0;
        n_write = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #12;
        chk_state(1'b0, "reset", 0, 1'b0);
        chk_state(1'b1, "reset", 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // LINEAR: load 5, count down to 0 with expiry pulse.
        //     sel tk wr ct en dur cnt ex
        step(0, 1, 0, 0, 0, 5, 5, 0);
        step(0, 1, 0, 0, 0, 5, 4, 0);
        step(0, 1, 0, 0, 0, 5, 3, 0);
        step(0, 1, 0, 0, 0, 5, 2, 0);
        step(0, 1, 0, 0, 0, 5, 1, 0);
        step(0, 1, 0, 0, 0, 5, 0, 1);
        step(0, 0, 0, 0, 0, 5, 0, 0);
        // Flag clear, counter 0: tick must not wrap.
        step(0, 1, 0, 0, 0, 5, 0, 0);

        // LINEAR: control=1 keeps reloading.
        step(0, 0, 1, 1, 0, 3, 0, 0);
        step(0, 1, 0, 1, 0, 3, 3, 0);
        step(0, 1, 0, 1, 0, 3, 3, 0);
        step(0, 1, 0, 1, 0, 3, 3, 0);
        step(0, 1, 0, 1, 0, 3, 3, 0);
        step(0, 1, 0, 0, 0, 3, 3, 0);
        step(0, 1, 0, 0, 0, 3, 2, 0);

        // LINEAR: write+tick at count 2, flag clear.
        step(0, 1, 1, 0, 0, 6, 6, 0);
        step(0, 1, 0, 0, 0, 6, 6, 0);
        step(0, 1, 0, 0, 0, 6, 5, 0);
        // Write alone does not touch the counter.
        step(0, 0, 1, 0, 0, 37, 5, 0);
        step(0, 1, 0, 0, 0, 37, 37, 0);
        async_reset("L37");
        step(0, 1, 0, 0, 0, 9, 9, 0);
        step(0, 1, 0, 0, 0, 9, 8, 0);

        // LENGTH: load 254 then decrement.
        step(1, 0, 1, 0, 1, 254, 254, 0);
        step(1, 1, 0, 0, 1, 254, 253, 0);
        step(1, 1, 0, 0, 1, 254, 252, 0);
        step(1, 1, 0, 0, 1, 254, 251, 0);
        // Halt holds.
        step(1, 1, 0, 1, 1, 254, 251, 0);
        step(1, 1, 0, 1, 1, 254, 251, 0);
        // Load wins over same-cycle tick.
        step(1, 1, 1, 0, 1, 10, 10, 0);
        step(1, 1, 0, 0, 1, 10, 9, 0);

        // LENGTH: disable clears without expiry, blocks writes.
        step(1, 0, 1, 0, 1, 40, 40, 0);
        step(1, 0, 0, 0, 0, 40, 0, 0);
        step(1, 0, 1, 0, 0, 20, 0, 0);
        step(1, 0, 0, 0, 1, 20, 0, 0);

        // LENGTH: expiry by decrement, none for a reload of 0.
        step(1, 0, 1, 0, 1, 2, 2, 0);
        step(1, 1, 0, 0, 1, 2, 1, 0);
        step(1, 1, 0, 0, 1, 2, 0, 1);
        step(1, 1, 0, 0, 1, 2, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);

        // LENGTH: async reset at 37.
        step(1, 0, 1, 0, 1, 37, 37, 0);
        async_reset("N37");
        step(1, 0, 0, 0, 1, 0, 0, 0);

        idle_inputs();
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() > 0) begin
            failures++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0",
                     q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apu_frame_counter_unit.md
Name: apu_frame_counter_unit

Overview:
- Parametrised successor of the APU triangle linear counter; one channel's frame-sequencer-driven down-counter.
- One source serves two jobs, selected by MODE:
  - LINEAR: triangle linear counter with a correct reload flag.
  - LENGTH: length counter used by the pulse, triangle and noise channels, with halt and channel-enable.
- Sits between the APU register-write decoder, the frame sequencer (quarter/half-frame ticks) and the channel output gate.

Parameters:
- WIDTH, 7, counter and duration width in bits (1..16).
- MODE, 0, 0 = LINEAR, 1 = LENGTH (values from apu_pkg).

Ports:
- iClk  in  1  system clock; all state on the rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iTick  in  1  single-cycle frame-sequencer enable: quarter-frame for LINEAR, half-frame for LENGTH.
- iWrite  in  1  single-cycle strobe for a CPU write to this channel's duration register.
- iControl_flag  in  1  LINEAR: control flag (1 keeps the reload flag set). LENGTH: halt (1 freezes decrement).
- iChannel_enable  in  1  LENGTH only (status register enable bit); ignored in LINEAR.
- iDuration  in  WIDTH  reload/load value.
- oData  out  1  counter nonzero; gates the channel output.
- oCount  out  WIDTH  current counter value.
- oExpired  out  1  one-cycle pulse: counter reached 0 by decrement.

Behaviour:
- Reset (async, immediate): counter = 0, reload_flag = 1, oExpired = 0. Therefore oData = 0 and oCount = 0.
- oData = (counter != 0) and oCount = counter. Both are combinational from registers, so there are 0 cycles from a register change to the output.
- All counter updates take effect on the edge after the qualifying input, a 1-cycle latency.
- LINEAR mode (reload_flag is internal):
  - iTick with reload_flag = 1: counter <= iDuration.
  - iTick with reload_flag = 0 and counter != 0: counter <= counter - 1.
  - iTick with reload_flag = 0 and counter = 0: counter stays 0, with no wrap.
  - On every iTick, if iControl_flag = 0 the reload flag clears (reload_flag <= 0).
  - iWrite: reload_flag <= 1. Counter is unchanged until the next iTick.
  - iWrite and iTick in the same cycle: the tick reloads, and reload_flag ends at 1 (write wins over the clear).
  - iChannel_enable has no effect.
- LENGTH mode (no reload flag):
  - iChannel_enable = 0: counter <= 0 every cycle, and iWrite is ignored. This overrides everything else.
  - iWrite with iChannel_enable = 1: counter <= iDuration.
  - iTick with iControl_flag = 0 and counter != 0: counter <= counter - 1.
  - iTick with iControl_flag = 1: counter holds.
  - iWrite and iTick in the same cycle: the load wins and no decrement is applied.
- oExpired:
  - Registered; asserted for exactly one cycle, on the edge where counter goes from 1 to 0 by decrement.
  - Not asserted for a forced clear (channel disable), for a reload of 0, or for reset.
- Width rules:
  - Decrement is modulo-free because it is guarded by counter != 0.
  - iDuration is taken at full WIDTH with no truncation.
- Reset mid-count: counter is 0 immediately. In LINEAR mode the next iTick reloads, since the reload flag is set.
- iTick and iWrite are level-sampled each cycle. If either is held high for multiple cycles, each cycle counts as a separate event.

Decomposition:
- apu_pkg holds:
  - localparams MODE_LINEAR = 0 and MODE_LENGTH = 1;
  - APU_LINEAR_W = 7 and APU_LENGTH_W = 8 (the length-table output width).
- No sub-module. MODE is resolved with generate-if inside one module.
- The length-table lookup (5-bit index to 8-bit value) stays in the register decoder, not in this block.

Test Plan:
- LINEAR, WIDTH=7: reset, iDuration=5, iControl_flag=0, then one iTick, then 5 iTicks.
  - Required: counter=5 after the first tick, then 4,3,2,1,0. oExpired is high for 1 cycle at 0. oData falls with the counter.
- LINEAR, iControl_flag=1, iDuration=3: four iTicks.
  - Required: counter stays 3, because the reload flag stays set.
  - Then set iControl_flag=0 and apply 2 iTicks: 3 (reload, flag clears), then 2.
- LINEAR, counter=2 with flag clear: iWrite and iTick in the same cycle with iDuration=6.
  - Required: counter=6 and reload_flag=1. The next iTick, with control 0, gives 6 again, then 5.
- LENGTH, WIDTH=8: enable=1, iWrite with iDuration=254, then 3 iTicks with halt=0.
  - Required: 254, 253, 252, 251.
  - Then halt=1 and 2 iTicks: holds at 251.
  - Then iWrite and iTick together with iDuration=10: counter=10, not 9.
- LENGTH: counter=40, drop iChannel_enable.
  - Required: counter=0 next cycle with no oExpired.
  - iWrite with iDuration=20 while disabled: counter stays 0.
- Assert iReset asynchronously mid-cycle while counter=37 in both modes.
  - Required: oCount=0, oData=0, oExpired=0 before the next edge.
  - LINEAR: the first iTick after reset loads iDuration.
